// File: rtl/mux16_rr_arbiter.sv
// ============================================================================
// mux16_rr_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter/sequencer for a 16:1 single-bit output mux. Sixteen
// requesters each own one mux input. The block picks one requester, drives the
// mux select and a one-hot grant, and holds both until the owner releases,
// drops its request or reaches the hold limit. Exactly one idle (bubble) cycle
// separates consecutive grants, so the mux select settles before the new owner
// sees its grant.
//
// Parameters
//   MAX_HOLD   max consecutive grant cycles per grant, 0 = unlimited (0..255)
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   req        in   16  level request per mux input (bit i = mux input i)
//   release_i  in   1   current owner done, only looked at while granted
//   sel        out  4   registered mux select
//   gnt        out  16  registered one-hot grant, 0 when no owner
//   gnt_valid  out  1   registered, high while gnt is non-zero
//   timeout    out  1   registered one-cycle pulse on forced rotation
// ============================================================================
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        release_i,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        gnt_valid,
    output logic        timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Last hold-counter value at which the grant is forced to end.
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 32'd0) ? 8'd0 : 8'(MAX_HOLD - 32'd1);
    localparam logic       HOLD_EN   = (MAX_HOLD != 32'd0);

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] gnt_q, gnt_d;
    logic        gnt_valid_q, gnt_valid_d;
    logic        timeout_q, timeout_d;

    logic [3:0]  winner_s;
    logic        found_s;
    logic [3:0]  cand_s;
    logic        owner_req_s;
    logic        limit_hit_s;
    logic        exit_s;

    // Rotating priority search: first requester at or after ptr, wrapping at 16.
    always_comb begin
        winner_s = 4'd0;
        found_s  = 1'b0;
        cand_s   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            cand_s   = ptr_q + 4'(k);
            winner_s = (!found_s && req[cand_s]) ? cand_s : winner_s;
            found_s  = found_s | req[cand_s];
        end
    end

    // Grant exit conditions for the current owner.
    always_comb begin
        owner_req_s = req[sel_q];
        limit_hit_s = HOLD_EN && (hold_q == HOLD_LAST);
        exit_s      = release_i || !owner_req_s || limit_hit_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d     = ST_GRANT;
                    sel_d       = winner_s;
                    gnt_d       = 16'd1 << winner_s;
                    gnt_valid_d = 1'b1;
                    hold_d      = 8'd0;
                end else begin
                    gnt_d       = 16'd0;
                    gnt_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (exit_s) begin
                    state_d     = ST_IDLE;
                    gnt_d       = 16'd0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = sel_q + 4'd1;
                    // Forced rotation only when the owner still wanted the mux.
                    timeout_d   = limit_hit_s && !release_i && owner_req_s;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 16'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 4'd0;
            hold_q      <= 8'd0;
            sel_q       <= 4'd0;
            gnt_q       <= 16'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// ============================================================================
// tb_mux16_rr_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for mux16_rr_arbiter. A behavioural model tracks the
// current owner (or none), how many cycles it has held the grant, and the
// round-robin pointer; every cycle the DUT outputs are compared to it.
// Directed scenarios come first, followed by randomized traffic.
// ============================================================================
module tb_mux16_rr_arbiter;

    localparam int MH = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        release_i;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic        timeout;

    int n_checks;
    int n_fail;

    // Reference model state.
    int          m_owner;   // -1 when nobody owns the mux
    int          m_held;    // grant cycles already seen by the owner
    int          m_ptr;
    int          m_sel;
    logic        m_timeout;

    mux16_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge(input logic [15:0] r, input logic rel, input logic rn);
        bit limit;
        if (!rn) begin
            m_owner   = -1;
            m_held    = 0;
            m_ptr     = 0;
            m_sel     = 0;
            m_timeout = 1'b0;
        end else if (m_owner < 0) begin
            m_timeout = 1'b0;
            if (r != 16'd0) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_owner < 0 && r[(m_ptr + k) % 16]) m_owner = (m_ptr + k) % 16;
                end
                m_sel  = m_owner;
                m_held = 1;
            end
        end else begin
            limit = (MH != 0) && (m_held == MH);
            if (rel || !r[m_owner] || limit) begin
                m_timeout = limit && !rel && r[m_owner];
                m_ptr     = (m_owner + 1) % 16;
                m_owner   = -1;
            end else begin
                m_timeout = 1'b0;
                m_held    = m_held + 1;
            end
        end
    endtask

    task automatic step(input logic [15:0] r, input logic rel, input logic rn);
        logic [15:0] e_gnt;
        req       = r;
        release_i = rel;
        rst_n     = rn;
        @(posedge clk);
        model_edge(r, rel, rn);
        #1;
        e_gnt = 16'd0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        check_val("sel",       32'(sel),       32'(m_sel));
        check_val("gnt",       32'(gnt),       32'(e_gnt));
        check_val("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check_val("timeout",   32'(timeout),   32'(m_timeout));
    endtask

    initial begin
        int          gnt8_cycles;
        int          to_seen;
        logic [15:0] r;
        logic        rel;
        logic        rn;

        clk       = 1'b0;
        rst_n     = 1'b0;
        req       = 16'hFFFF;
        release_i = 1'b0;
        n_checks  = 0;
        n_fail    = 0;
        m_owner   = -1;
        m_held    = 0;
        m_ptr     = 0;
        m_sel     = 0;
        m_timeout = 1'b0;

        // 1: reset dominates a full request vector.
        step(16'hFFFF, 1'b0, 1'b0);
        step(16'hFFFF, 1'b0, 1'b0);
        check_val("rst_gnt", 32'(gnt), 32'd0);

        // 2: single requester 5, then release; pointer moves to 6.
        step(16'h0020, 1'b0, 1'b1);
        check_val("t2_sel", 32'(sel), 32'd5);
        step(16'h0020, 1'b1, 1'b1);
        check_val("t2_gnt0", 32'(gnt), 32'd0);

        // 3: requesters 0 and 15 alternate, exercising the 15->0 wrap.
        for (int i = 0; i < 8; i++) step(16'h8001, i[0], 1'b1);

        // 4: two steady requesters, no release: hold limit forces rotation.
        gnt8_cycles = 0;
        to_seen     = 0;
        for (int i = 0; i < 14; i++) begin
            step(16'h0018, 1'b0, 1'b1);
            if (gnt == 16'h0008) gnt8_cycles++;
            if (timeout) to_seen++;
        end
        check_val("t4_hold_len", 32'(gnt8_cycles), 32'(MH));
        check_val("t4_timeouts", 32'(to_seen), 32'd1);
        check_val("t4_next_gnt", 32'(gnt), 32'h0010);
        step(16'h0000, 1'b1, 1'b1);
        step(16'h0000, 1'b0, 1'b1);

        // 5: owner drops its request without release: normal exit.
        step(16'h0004, 1'b0, 1'b1);
        step(16'h0004, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        check_val("t5_timeout", 32'(timeout), 32'd0);

        // 6: reset in the middle of a grant to input 9.
        step(16'h0200, 1'b0, 1'b1);
        step(16'h0200, 1'b0, 1'b1);
        step(16'h0200, 1'b0, 1'b0);
        check_val("t6_sel_rst", 32'(sel), 32'd0);
        step(16'h0201, 1'b0, 1'b1);
        check_val("t6_gnt", 32'(gnt), 32'h0001);

        // Randomized traffic.
        r = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: r = 16'h0000;
                1: r = 16'd1 << $urandom_range(0, 15);
                2: r = 16'($urandom);
                default: r = r;
            endcase
            rel = ($urandom_range(0, 9) == 0);
            rn  = ($urandom_range(0, 199) != 0);
            step(r, rel, rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
